// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and widths for the UART port arbiter
package uart_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWNED, SEND, WAIT} arb_state_t;
  localparam int TIMER_W = 16;
  localparam int DROP_CNT_W = 8;
  // index width for up to four requesters; a 1-bit index keeps 2-way selects exact
  function automatic int idx_w(input int n);
    return (n > 2) ? 2 : 1;
  endfunction
endpackage

// File: rtl/uart_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker searching upward from last+1
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int LW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [LW-1:0] i_last,
  output logic [N-1:0]  o_win
);
  logic [LW-1:0] w_idx;
  // first requester found after the previous owner wins
  always_comb begin
    o_win = '0;
    w_idx = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = LW'((int'(i_last) + k) % N);
      if (o_win == '0 && i_req[w_idx]) o_win[w_idx] = 1'b1;
    end
  end
endmodule

// File: rtl/uart_port_arbiter.sv
// uart_port_arbiter: round-robin, transaction-locked sharing of one UART core
module uart_port_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  output logic [NREQ-1:0]       gnt,
  input  logic [NREQ-1:0]       tx_valid,
  input  logic [NREQ*8-1:0]     tx_data,
  output logic [NREQ-1:0]       tx_ready,
  output logic [NREQ-1:0]       rx_valid,
  output logic [7:0]            rx_data,
  output logic                  uart_tx_en,
  output logic [7:0]            uart_tx_data,
  input  logic                  uart_tx_done,
  input  logic                  uart_rx_done,
  input  logic [7:0]            uart_rx_data,
  output logic                  busy,
  output logic                  timeout,
  output logic [DROP_CNT_W-1:0] rx_drop_count
);
  localparam int LW = idx_w(NREQ);
  arb_state_t r_state, w_next;
  logic [NREQ-1:0] r_gnt, r_rx_valid, w_win;
  logic [LW-1:0] r_own, r_last, w_win_idx;
  logic [7:0] r_rx_data, r_tx_data;
  logic [TIMER_W-1:0] r_timer;
  logic [DROP_CNT_W-1:0] r_drop;
  logic r_timeout, w_tmo, w_rx_own;

  rr_pick #(.N(NREQ), .LW(LW)) u_pick (.i_req(req), .i_last(r_last), .o_win(w_win));

  assign w_tmo = r_timer == TIMEOUT_CYCLES - 1'b1;
  assign w_rx_own = uart_rx_done && r_state != IDLE;
  assign gnt = r_gnt;
  assign rx_valid = r_rx_valid;
  assign rx_data = r_rx_data;
  assign uart_tx_data = r_tx_data;
  assign timeout = r_timeout;
  assign rx_drop_count = r_drop;
  assign uart_tx_en = r_state == SEND;
  assign busy = r_state != IDLE;

  // convert the one-hot winner into an owner index
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) if (w_win[i]) w_win_idx = LW'(i);
  end

  // next state; tx_ready is a Mealy output of WAIT on tx_done
  always_comb begin
    w_next = r_state;
    tx_ready = '0;
    case (r_state)
      IDLE:  w_next = |req ? OWNED : IDLE;
      OWNED: w_next = !req[r_own] ? IDLE : tx_valid[r_own] ? SEND : OWNED;
      SEND:  w_next = WAIT;
      WAIT: begin
        tx_ready = uart_tx_done ? r_gnt : '0;
        w_next = (uart_tx_done || w_tmo) ? OWNED : WAIT;
      end
      default: w_next = IDLE;
    endcase
  end

  // state, ownership, outgoing byte and tx_done timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_own <= '0;
      r_last <= LW'(NREQ - 1);
      r_tx_data <= '0;
      r_timer <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (|req) begin
          r_gnt <= w_win;
          r_own <= w_win_idx;
        end
        OWNED: if (!req[r_own]) begin
          r_last <= r_own;
          r_gnt <= '0;
        end else if (tx_valid[r_own]) r_tx_data <= tx_data[{r_own, 3'b000} +: 8];
        SEND: r_timer <= '0;
        WAIT: if (!uart_tx_done) begin
          if (w_tmo) r_timeout <= 1'b1;
          else r_timer <= r_timer + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // steer received bytes to the owner, count those arriving with no owner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_valid <= '0;
      r_rx_data <= '0;
      r_drop <= '0;
    end else begin
      r_rx_valid <= w_rx_own ? r_gnt : '0;
      if (w_rx_own) r_rx_data <= uart_rx_data;
      if (uart_rx_done && r_state == IDLE && r_drop != '1) r_drop <= r_drop + 1'b1;
    end
  end
endmodule
